alu_result_skid_stage: RTL
==========================

// Module: alu_result_skid_stage
// PURPOSE
//  Parametrised ALU-to-writeback pipeline register for the processor datapath.
//  Carries NUM_LANES result words, a FLAG_W flag nibble and a destination tag.
//  Uses a valid/ready handshake with a 2-entry skid buffer: full throughput, and in_ready is registered.
//  Adds flush, a stall-cycle counter and an occupancy output.
// PARAMETERS
//  WIDTH      8   bits per result lane
//  NUM_LANES  2   result lanes (lane 0 = primary result, lane 1 = secondary operand/result)
//  FLAG_W     4   ALU flag width (N,Z,C,V at default)
//  TAG_W      4   destination register tag width
//  CNT_W      16  stall counter width
// PORTS
//  clk        in   1                  clock, all logic on posedge
//  reset      in   1                  synchronous, active-high; clears all state
//  flush      in   1                  synchronous; discards all buffered entries
//  in_valid   in   1                  upstream entry present
//  in_ready   out  1                  stage accepts an entry this cycle (registered)
//  in_data    in   NUM_LANES*WIDTH    lane i at [i*WIDTH +: WIDTH]
//  in_flags   in   FLAG_W             ALU flags
//  in_tag     in   TAG_W              destination tag
//  out_valid  out  1                  head entry present
//  out_ready  in   1                  downstream consumes the head entry
//  out_data   out  NUM_LANES*WIDTH    head entry payload
//  out_flags  out  FLAG_W             head entry flags
//  out_tag    out  TAG_W              head entry tag
//  occupancy  out  2                  entries held: 0, 1 or 2
//  stall_cnt  out  CNT_W              cycles with out_valid && !out_ready (saturating)
// BEHAVIOUR
//  - Accept = in_valid && in_ready. Pop = out_valid && out_ready.
//  - Storage: MAIN entry (drives outputs) and SKID entry. State EMPTY/ONE/FULL.
//  - EMPTY: on accept, load MAIN -> ONE.
//  - ONE:
//    - accept & pop: reload MAIN, stay ONE.
//    - accept & !pop: load SKID -> FULL.
//    - pop & !accept -> EMPTY.
//  - FULL: in_ready=0, so accept is impossible. On pop, SKID -> MAIN -> ONE.
//  - in_ready = (next_state != FULL), registered. It is 1 in EMPTY/ONE and 0 in FULL.
//  - Latency: accepted entry appears on out_* the next cycle. Sustained 1 entry/cycle when out_ready=1.
//  - FIFO order strictly preserved; payload never modified.
//  - Priority: reset > flush > handshake.
//    - reset: state EMPTY; all payload regs 0; in_ready=1; out_valid=0; out_data/flags/tag=0; occupancy=0; stall_cnt=0.
//    - flush: state EMPTY and in_ready=1 next cycle. Any same-cycle accept is dropped. The pop that cycle is still seen downstream. Payload regs retain values (don't-care while out_valid=0). stall_cnt not cleared.
//  - out_valid = (state != EMPTY). Downstream must not read payload when out_valid=0.
//  - occupancy = 0/1/2 for EMPTY/ONE/FULL.
//  - stall_cnt increments when out_valid && !out_ready. Holds at 2**CNT_W-1. Cleared by reset only.
//  - Reset mid-operation: contents lost, no partial outputs. First cycle after reset release is EMPTY.
//  - Illegal state encoding recovers to EMPTY.
// STRUCTURE
//  - Package alu_pipe_pkg:
//    - typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t
//    - struct type alu_entry_t {data, flags, tag}, parametrised via localparams
//  - Sub-module alu_entry_reg: load-enabled, sync-reset register for one alu_entry_t.
//    - Instantiated twice, MAIN and SKID.
//  - Top holds FSM, in_ready register and stall counter.
// TESTING
//  1. reset=1 for 2 cycles -> out_valid=0, in_ready=1, occupancy=0, stall_cnt=0, out_data=0.
//  2. Stream data 0x11..0x15, out_ready=1 -> each appears 1 cycle later in order; in_ready stays 1; occupancy=1.
//  3. Push 0xA1, 0xA2 with out_ready=0 -> occupancy=2, in_ready=0.
//     - Raise out_ready -> 0xA1 then 0xA2 out, in_ready back to 1.
//  4. out_ready=0 for 5 cycles with 1 entry held -> stall_cnt=5.
//     - CNT_W=3, hold 10 cycles -> stall_cnt=7.
//  5. FULL, flush=1 with in_valid=1 (data 0xFF) -> next cycle occupancy=0, out_valid=0.
//     - 0xFF never emitted; stall_cnt unchanged.
//  6. reset asserted while FULL with accept pending -> next cycle all outputs at reset values.
//     - NUM_LANES=4, WIDTH=16: lane 3 value 0xBEEF passes intact.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared types for the ALU-to-writeback pipeline stage: skid-buffer state
// encoding, the default-width entry record and the occupancy decode.
package alu_pipe_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int NUM_LANES_DEF = 2;
  localparam int FLAG_W_DEF    = 4;
  localparam int TAG_W_DEF     = 4;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // One buffered ALU result at the default widths.
  typedef struct packed {
    logic [NUM_LANES_DEF*WIDTH_DEF-1:0] data;
    logic [FLAG_W_DEF-1:0]              flags;
    logic [TAG_W_DEF-1:0]               tag;
  } alu_entry_t;

  // Number of entries held in a given state; unknown encodings read as empty.
  function automatic logic [1:0] occupancy_of(skid_state_t s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu_entry_reg.sv
// Load-enabled register holding one ALU result entry.
module alu_entry_reg
  import alu_pipe_pkg::*;
#(
  parameter type entry_t = alu_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  entry_t d,
  output entry_t q
);

  // Capture the entry when loaded; clear it on reset.
  always_ff @(posedge clk) begin
    // NOTE: payload is cleared on reset so the outputs read zero while empty,
    // even though consumers ignore them whenever out_valid is low.
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_result_skid_stage.sv
// ALU-to-writeback pipeline register with a two-entry skid buffer. in_ready is
// registered, yet the stage sustains one entry per cycle when downstream is ready.
module alu_result_skid_stage
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int FLAG_W    = FLAG_W_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_LANES*WIDTH-1:0] in_data,
  input  logic [FLAG_W-1:0]          in_flags,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output logic [FLAG_W-1:0]          out_flags,
  output logic [TAG_W-1:0]           out_tag,
  output logic [1:0]                 occupancy,
  output logic [CNT_W-1:0]           stall_cnt
);

  typedef struct packed {
    logic [NUM_LANES*WIDTH-1:0] data;
    logic [FLAG_W-1:0]          flags;
    logic [TAG_W-1:0]           tag;
  } entry_t;

  skid_state_t state;
  skid_state_t next_state;
  logic        accept;
  logic        pop;
  logic        main_load;
  logic        skid_load;
  entry_t      in_entry;
  entry_t      main_d;
  entry_t      main_q;
  entry_t      skid_q;

  assign in_entry  = '{data: in_data, flags: in_flags, tag: in_tag};
  assign out_valid = (state == ONE) || (state == FULL);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = main_q.data;
  assign out_flags = main_q.flags;
  assign out_tag   = main_q.tag;
  assign occupancy = occupancy_of(state);

  // Next state and load enables; flush empties the buffer and drops any accept.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned and infers a latch.
    next_state = EMPTY;
    main_load  = 1'b0;
    skid_load  = 1'b0;
    main_d     = in_entry;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state = ONE;
          main_load  = 1'b1;
        end
      end
      ONE: begin
        next_state = ONE;
        if (accept && pop) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load  = 1'b1;
          next_state = FULL;
        end else if (pop) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        next_state = FULL;
        if (pop) begin
          next_state = ONE;
          main_load  = 1'b1;
          main_d     = skid_q;
        end
      end
      default: next_state = EMPTY;
    endcase
    if (flush) begin
      next_state = EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
    end
  end

  // State, registered in_ready and the saturating stall counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      stall_cnt <= '0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != FULL);
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  alu_entry_reg #(.entry_t(entry_t)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  alu_entry_reg #(.entry_t(entry_t)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (in_entry),
    .q     (skid_q)
  );

endmodule
